// File: rtl/aluop_stage_if.sv
// ============================================================================
// aluop_stage_if : upstream/downstream handshake bundle for aluop_stage
// Revision: 1.0
// ============================================================================
`default_nettype none

interface aluop_stage_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid_i;
    logic [31:0]      in_instr_i;
    logic             in_ready_o;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      out_instr_o;
    logic [2:0]       aluop_o;
    logic [3:0]       alu_ctrl_o;
    logic             mext_o;
    logic             illegal_o;
    logic [CNT_W-1:0] illegal_cnt_o;

    // Stage side
    modport slave (
        input  in_valid_i, in_instr_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, out_instr_o, aluop_o, alu_ctrl_o,
               mext_o, illegal_o, illegal_cnt_o
    );

    // Environment side (fetch upstream plus execute downstream)
    modport master (
        output in_valid_i, in_instr_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_instr_o, aluop_o, alu_ctrl_o,
               mext_o, illegal_o, illegal_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/aluop_stage.sv
// ============================================================================
// aluop_stage : RV32 ALU-op decode stage with a two-entry skid buffer
// Revision: 1.0
// ============================================================================
`default_nettype none

module aluop_stage #(
    parameter bit M_EXT = 1'b0,
    parameter int CNT_W = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    aluop_stage_if.slave  bus
);

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  aluop;
        logic [3:0]  ctrl;
        logic        mext;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    entry_t           dec;
    entry_t           out_q;
    entry_t           skid_q;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             drain;
    logic             load_out;
    logic             load_skid;
    logic             out_from_skid;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = bus.in_instr_i[6:0];
    assign funct3 = bus.in_instr_i[14:12];
    assign funct7 = bus.in_instr_i[31:25];

    always_comb begin
        dec       = '0;
        dec.instr = bus.in_instr_i;
        case (opcode)
            7'b0110011: begin
                dec.aluop = 3'b000;
                dec.ctrl  = {funct7[5], funct3};
                if (funct7 == 7'b0000001) begin
                    if (M_EXT) begin
                        dec.mext = 1'b1;
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end else if (funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0010011: begin
                dec.aluop = 3'b001;
                // Only the shift-right group uses funct7[5] (SRLI vs SRAI)
                dec.ctrl  = (funct3 == 3'b101) ? {funct7[5], funct3} : {1'b0, funct3};
            end
            7'b1100011: begin
                dec.aluop = 3'b010;
                dec.ctrl  = {1'b0, funct3};
            end
            7'b1100111: dec.aluop = 3'b011;
            7'b1101111: dec.aluop = 3'b011;
            7'b0000011: dec.aluop = 3'b100;
            7'b0100011: dec.aluop = 3'b101;
            7'b0110111: dec.aluop = 3'b110;
            7'b0010111: dec.aluop = 3'b111;
            default:    dec.illegal = 1'b1;
        endcase
    end

    // in_ready depends on state alone so out_ready never reaches it combinationally
    assign accept = bus.in_valid_i && (state != TWO);
    assign drain  = (state != EMPTY) && bus.out_ready_i;

    always_comb begin
        state_nxt     = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (accept) begin
                    state_nxt = ONE;
                    load_out  = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_out = 1'b1;
                end else if (accept) begin
                    state_nxt = TWO;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (drain) begin
                    state_nxt     = ONE;
                    load_out      = 1'b1;
                    out_from_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush_i) begin
            state_nxt = EMPTY;
            load_out  = 1'b0;
            load_skid = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out) begin
                out_q <= out_from_skid ? skid_q : dec;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    // Counts delivered illegal entries, including one that leaves alongside a flush
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt <= '0;
        end else if (drain && out_q.illegal && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready_o    = (state != TWO);
    assign bus.out_valid_o   = (state != EMPTY);
    assign bus.out_instr_o   = out_q.instr;
    assign bus.aluop_o       = out_q.aluop;
    assign bus.alu_ctrl_o    = out_q.ctrl;
    assign bus.mext_o        = out_q.mext;
    assign bus.illegal_o     = out_q.illegal;
    assign bus.illegal_cnt_o = cnt;

endmodule

`default_nettype wire

// File: tb/tb_aluop_stage.sv
// ============================================================================
// tb_aluop_stage : scoreboard bench, one DUT with M_EXT=0/CNT_W=8, one with M_EXT=1/CNT_W=2
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_aluop_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  aluop;
        logic [3:0]  ctrl;
        logic        mext;
        logic        illegal;
    } ent_t;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  al;
        logic [3:0]  ct;
        logic        il0;
        logic        mx0;
        logic        il1;
        logic        mx1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    int total = 0;
    int bad   = 0;
    int cnt_a = 0;
    int cnt_b = 0;
    ent_t qa[$];
    ent_t qb[$];
    vec_t vt[16];

    always #5 clk = ~clk;

    aluop_stage_if #(.CNT_W(8)) ifa ();
    aluop_stage_if #(.CNT_W(2)) ifb ();

    assign ifa.in_valid_i  = in_valid;
    assign ifa.in_instr_i  = instr;
    assign ifa.flush_i     = flush;
    assign ifa.out_ready_i = out_ready;
    assign ifb.in_valid_i  = in_valid;
    assign ifb.in_instr_i  = instr;
    assign ifb.flush_i     = flush;
    assign ifb.out_ready_i = out_ready;

    aluop_stage #(.M_EXT(1'b0), .CNT_W(8)) u_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
    aluop_stage #(.M_EXT(1'b1), .CNT_W(2)) u_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input vec_t v);
        int w = 0;
        in_valid = 1'b1;
        instr    = v.ins;
        while (!ifa.in_ready_o && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (!ifa.in_ready_o) begin
            total++;
            bad++;
            $display("FAIL send_timeout: instr %08h never accepted", v.ins);
        end else begin
            @(posedge clk);
            qa.push_back(ent_t'{v.ins, v.al, v.ct, v.mx0, v.il0});
            qb.push_back(ent_t'{v.ins, v.al, v.ct, v.mx1, v.il1});
            #1;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid_a"}, ifa.out_valid_o, 0);
        check({tag, "_ready_a"}, ifa.in_ready_o, 1);
        check({tag, "_instr_a"}, ifa.out_instr_o, 0);
        check({tag, "_aluop_a"}, ifa.aluop_o, 0);
        check({tag, "_ctrl_a"},  ifa.alu_ctrl_o, 0);
        check({tag, "_mext_a"},  ifa.mext_o, 0);
        check({tag, "_ill_a"},   ifa.illegal_o, 0);
        check({tag, "_cnt_a"},   ifa.illegal_cnt_o, 0);
        check({tag, "_valid_b"}, ifb.out_valid_o, 0);
        check({tag, "_cnt_b"},   ifb.illegal_cnt_o, 0);
    endtask

    // Monitor: compares the presented entry with the queue head every cycle it is valid
    always @(negedge clk) begin
        if (!rst) begin
            ent_t act;
            check("cnt_a", ifa.illegal_cnt_o, cnt_a);
            check("cnt_b", ifb.illegal_cnt_o, cnt_b);
            if (ifa.out_valid_o) begin
                act = '{ifa.out_instr_o, ifa.aluop_o, ifa.alu_ctrl_o, ifa.mext_o, ifa.illegal_o};
                if (qa.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_a: got %0h expected none", act);
                end else begin
                    check("entry_a", act, qa[0]);
                    if (out_ready) begin
                        if (qa[0].illegal && cnt_a != 255) cnt_a++;
                        void'(qa.pop_front());
                    end
                end
            end
            if (ifb.out_valid_o) begin
                act = '{ifb.out_instr_o, ifb.aluop_o, ifb.alu_ctrl_o, ifb.mext_o, ifb.illegal_o};
                if (qb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_b: got %0h expected none", act);
                end else begin
                    check("entry_b", act, qb[0]);
                    if (out_ready) begin
                        if (qb[0].illegal && cnt_b != 3) cnt_b++;
                        void'(qb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        //          instr          aluop   ctrl    il0   mx0   il1   mx1
        vt[0]  = '{32'h402081B3, 3'd0, 4'h8, 1'b0, 1'b0, 1'b0, 1'b0}; // SUB
        vt[1]  = '{32'h002081B3, 3'd0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // ADD
        vt[2]  = '{32'h00500093, 3'd1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // ADDI
        vt[3]  = '{32'h40315093, 3'd1, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0}; // SRAI
        vt[4]  = '{32'hFFF12093, 3'd1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0}; // SLTI, imm bit30 ignored
        vt[5]  = '{32'h00209063, 3'd2, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0}; // BNE
        vt[6]  = '{32'h000000EF, 3'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // JAL
        vt[7]  = '{32'h00008067, 3'd3, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // JALR
        vt[8]  = '{32'h00012083, 3'd4, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // LW
        vt[9]  = '{32'h00112023, 3'd5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // SW
        vt[10] = '{32'h123450B7, 3'd6, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // LUI
        vt[11] = '{32'h00000097, 3'd7, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0}; // AUIPC
        vt[12] = '{32'h0000007F, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0}; // bad opcode
        vt[13] = '{32'h022081B3, 3'd0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1}; // MUL
        vt[14] = '{32'h802081B3, 3'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0}; // bad funct7
        vt[15] = '{32'h4020D1B3, 3'd0, 4'hD, 1'b0, 1'b0, 1'b0, 1'b0}; // SRA

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single SUB, then one-cycle latency
        out_ready = 1'b1;
        send(vt[0]);
        check("latency_valid", ifa.out_valid_o, 1);
        check("latency_ctrl", ifa.alu_ctrl_o, 4'h8);
        // Remaining vectors back to back at full rate
        for (int i = 1; i < 16; i++) send(vt[i]);
        idle(4);
        check("cnt_a_after_table", ifa.illegal_cnt_o, 3);
        check("cnt_b_after_table", ifb.illegal_cnt_o, 2);

        // Backpressure: two accepted, third held off until release
        out_ready = 1'b0;
        send(vt[0]);
        send(vt[1]);
        check("ready_low_two", ifa.in_ready_o, 0);
        in_valid = 1'b1;
        instr    = vt[2].ins;
        repeat (3) @(posedge clk);
        #1;
        check("ready_still_low", ifa.in_ready_o, 0);
        check("hold_instr", ifa.out_instr_o, vt[0].ins);
        out_ready = 1'b1;
        send(vt[2]);
        idle(4);

        // Flush in TWO with a concurrent offer
        out_ready = 1'b0;
        send(vt[3]);
        send(vt[5]);
        flush    = 1'b1;
        in_valid = 1'b1;
        instr    = vt[6].ins;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        qa.delete();
        qb.delete();
        check("flush_valid", ifa.out_valid_o, 0);
        check("flush_ready", ifa.in_ready_o, 1);
        check("flush_cnt_a", ifa.illegal_cnt_o, 3);
        out_ready = 1'b1;
        idle(2);

        // Illegal entry leaves in the same cycle as a flush: still counted
        send(vt[12]);
        flush = 1'b1;
        instr = vt[0].ins;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        qa.delete();
        qb.delete();
        check("flushx_valid", ifa.out_valid_o, 0);
        check("flushx_cnt_a", ifa.illegal_cnt_o, 4);
        check("flushx_cnt_b", ifb.illegal_cnt_o, 3);
        idle(2);

        // Saturation of the narrow counter
        for (int i = 0; i < 5; i++) send(vt[12]);
        idle(4);
        check("sat_cnt_b", ifb.illegal_cnt_o, 3);
        check("sat_cnt_a", ifa.illegal_cnt_o, 9);

        // Asynchronous reset between edges with two entries buffered
        out_ready = 1'b0;
        send(vt[12]);
        send(vt[4]);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async");
        qa.delete();
        qb.delete();
        cnt_a = 0;
        cnt_b = 0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        send(vt[15]);
        idle(4);

        check("qa_drained", qa.size(), 0);
        check("qb_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
